// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_ctrl
// Purpose  : Instruction memory for the IF stage. After reset a sweep fills
//            every word with INIT_WORD. A host can then load a program while
//            the core is held (busy). Fetches are registered and support
//            stall, flush-to-NOP, a valid flag and an out-of-range fault.
// Ports    : clk, rst (async, active-low)
//            pc, fetch_en, stall, flush             - fetch side
//            load_en, load_we, load_addr, load_data - host load side
//            instr, instr_valid, addr_fault         - registered fetch result
//            busy                                   - INIT or LOAD in progress
//            load_err                               - sticky bad load address
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] INIT_WORD = 16'h1010,
  parameter logic [DATA_W-1:0] NOP_WORD  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic              busy,
  output logic              load_err
);

  localparam int                 c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Addresses are compared one bit wider so DEPTH == 2^ADDR_W is representable.
  localparam logic [ADDR_W:0]    c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_IDX_W-1:0]  r_init_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   r_instr;
  logic                r_instr_valid;
  logic                r_addr_fault;
  logic                r_load_err;

  logic                w_pc_ok;
  logic                w_ld_ok;
  logic [c_IDX_W-1:0]  w_pc_idx;
  logic [c_IDX_W-1:0]  w_ld_idx;
  logic                w_mem_we;
  logic [c_IDX_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;

  // Full-width range checks; the low index bits are only used once a check passes.
  assign w_pc_ok  = ({1'b0, pc} < c_DEPTH_EXT);
  assign w_ld_ok  = ({1'b0, load_addr} < c_DEPTH_EXT);
  assign w_pc_idx = pc[c_IDX_W-1:0];
  assign w_ld_idx = load_addr[c_IDX_W-1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == c_LAST_IDX) w_state_nxt = S_RUN;
      S_RUN:   if (load_en)                  w_state_nxt = S_LOAD;
      S_LOAD:  if (!load_en)                 w_state_nxt = S_RUN;
      default:                               w_state_nxt = S_INIT;
    endcase
  end

  // -------------------------------------------------------- memory write port
  // The sweep and the host share one write port; they never overlap in time.
  // Writes are gated by rst so the array is untouched while reset is held.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_data = '0;
    case (r_state)
      S_INIT: begin
        w_mem_we   = rst;
        w_mem_addr = r_init_cnt;
        w_mem_data = INIT_WORD;
      end
      S_LOAD: begin
        w_mem_we   = rst && load_we && w_ld_ok;
        w_mem_addr = w_ld_idx;
        w_mem_data = load_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // ------------------------------------------------ init counter, fetch regs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_cnt    <= '0;
      r_instr       <= NOP_WORD;
      r_instr_valid <= 1'b0;
      r_addr_fault  <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      // Held at zero outside INIT so any later sweep starts from index 0.
      r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + 1'b1 : '0;

      r_instr       <= NOP_WORD;
      r_instr_valid <= 1'b0;
      r_addr_fault  <= 1'b0;

      if (r_state == S_RUN) begin
        if (flush) begin
          r_instr       <= NOP_WORD;
          r_instr_valid <= 1'b0;
          r_addr_fault  <= 1'b0;
        end else if (stall) begin
          r_instr       <= r_instr;
          r_instr_valid <= r_instr_valid;
          r_addr_fault  <= r_addr_fault;
        end else if (fetch_en) begin
          if (w_pc_ok) begin
            r_instr       <= r_mem[w_pc_idx];
            r_instr_valid <= 1'b1;
          end else begin
            r_addr_fault  <= 1'b1;
          end
        end
        // A fresh load session starts with a clean error flag.
        if (load_en) begin
          r_load_err <= 1'b0;
        end
      end else if (r_state == S_LOAD) begin
        if (load_we && !w_ld_ok) begin
          r_load_err <= 1'b1;
        end
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign addr_fault  = r_addr_fault;
  assign busy        = (r_state != S_RUN);
  assign load_err    = r_load_err;

endmodule
`default_nettype wire
